// File: rtl/uncached_axi_master_if.sv
// Bus bundle for the uncached data path: sram_like side plus AXI3 channels.
// The master modport is the bridge-facing AXI master; slave is the opposite end.
interface uncached_axi_master_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        addr_ok;
  logic        data_ok;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata_axi;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;

  logic [3:0]  wid;
  logic [31:0] wdata_axi;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    input  req, wr, size, addr, wdata,
    output rdata, addr_ok, data_ok,
    output arid, araddr, arlen, arsize, arburst,
    output arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata_axi, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst,
    output awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata_axi, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    output req, wr, size, addr, wdata,
    input  rdata, addr_ok, data_ok,
    input  arid, araddr, arlen, arsize, arburst,
    input  arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata_axi, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst,
    input  awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata_axi, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/uncached_axi_master.sv
// Single-outstanding sram_like to AXI3 master for uncached/MMIO accesses.
// Optional `UNCACHED_RESP_CHECK_EN enables the sticky err flag on bad resp.
module uncached_axi_master #(
  parameter logic [3:0] AXI_ID = 4'd1
) (
  input  logic                        clk,
  input  logic                        rst,
  uncached_axi_master_if.master       bus,
  output logic                        err
);

  typedef enum logic [2:0] {
    IDLE, AR, R, AW_W, B, DONE
  } state_t;

  state_t      state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [1:0]  size_q;
  logic        aw_done;
  logic        w_done;
  logic        arvalid_q;
  logic        rready_q;
  logic        awvalid_q;
  logic        wvalid_q;
  logic        bready_q;
  logic        data_ok_q;
  logic        aw_hs;
  logic        w_hs;
  logic        aw_ok;
  logic        w_ok;
  logic [3:0]  strb;

  assign bus.addr_ok = bus.req & ~rst & (state == IDLE);

  assign aw_hs = awvalid_q & bus.awready;
  assign w_hs  = wvalid_q & bus.wready;
  assign aw_ok = aw_done | aw_hs;
  assign w_ok  = w_done | w_hs;

  assign bus.rdata   = rdata_q;
  assign bus.data_ok = data_ok_q;

  assign bus.arid    = AXI_ID;
  assign bus.araddr  = addr_q;
  assign bus.arlen   = 4'd0;
  assign bus.arsize  = {1'b0, size_q};
  assign bus.arburst = 2'b01;
  assign bus.arlock  = 2'b00;
  assign bus.arcache = 4'd0;
  assign bus.arprot  = 3'd0;
  assign bus.arvalid = arvalid_q;
  assign bus.rready  = rready_q;

  assign bus.awid    = AXI_ID;
  assign bus.awaddr  = addr_q;
  assign bus.awlen   = 4'd0;
  assign bus.awsize  = {1'b0, size_q};
  assign bus.awburst = 2'b01;
  assign bus.awlock  = 2'b00;
  assign bus.awcache = 4'd0;
  assign bus.awprot  = 3'd0;
  assign bus.awvalid = awvalid_q;

  assign bus.wid       = AXI_ID;
  assign bus.wdata_axi = wdata_q;
  assign bus.wstrb     = strb;
  assign bus.wlast     = 1'b1;
  assign bus.wvalid    = wvalid_q;
  assign bus.bready    = bready_q;

  // byte-lane strobes from the latched size and low address bits
  always_comb begin
    strb = 4'b1111;
    unique case (1'b1)
      size_q == 2'd0: strb = 4'b0001 << addr_q[1:0];
      size_q == 2'd1: strb = addr_q[1] ? 4'b1100 : 4'b0011;
      default:        strb = 4'b1111;
    endcase
  end

  // request FSM with registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      rdata_q   <= 32'd0;
      size_q    <= 2'd0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      data_ok_q <= 1'b0;
    end else begin
      data_ok_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.req) begin
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
            size_q  <= (bus.size == 2'd3) ? 2'd2 : bus.size;
            if (bus.wr) begin
              state     <= AW_W;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
            end else begin
              state     <= AR;
              arvalid_q <= 1'b1;
            end
          end
        end
        AR: begin
          if (bus.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state     <= R;
          end
        end
        R: begin
          if (bus.rvalid) begin
            rready_q  <= 1'b0;
            rdata_q   <= bus.rdata_axi;
            data_ok_q <= 1'b1;
            state     <= DONE;
          end
        end
        AW_W: begin
          if (aw_hs) begin
            awvalid_q <= 1'b0;
            aw_done   <= 1'b1;
          end
          if (w_hs) begin
            wvalid_q <= 1'b0;
            w_done   <= 1'b1;
          end
          if (aw_ok & w_ok) begin
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            bready_q <= 1'b1;
            state    <= B;
          end
        end
        B: begin
          if (bus.bvalid) begin
            bready_q  <= 1'b0;
            data_ok_q <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UNCACHED_RESP_CHECK_EN
  logic unused_ids;
  assign unused_ids = ^{bus.rid, bus.rlast, bus.bid};

  // sticky error on any non-OKAY read or write response
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if ((state == R && bus.rvalid && bus.rresp != 2'b00) ||
                 (state == B && bus.bvalid && bus.bresp != 2'b00)) begin
      err <= 1'b1;
    end
  end
`else
  logic unused_ids;
  assign unused_ids = ^{bus.rid, bus.rlast, bus.bid, bus.rresp, bus.bresp};
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_uncached_axi_master.sv
// Scoreboard bench for uncached_axi_master with a randomized AXI slave.
// Reference model tracks memory bytewise and predicts bus fields and data.
module tb_uncached_axi_master;

  logic clk = 1'b0;
  logic rst;
  logic err;

  always #5 clk = ~clk;

  uncached_axi_master_if bus();

  uncached_axi_master #(.AXI_ID(4'd1)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .err(err)
  );

`ifdef UNCACHED_RESP_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] a;
    logic [2:0]  sz;
  } aexp_t;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  s;
  } wexp_t;

  typedef struct packed {
    logic        rd;
    logic [31:0] d;
  } dexp_t;

  aexp_t exp_ar[$];
  aexp_t exp_aw[$];
  wexp_t exp_w[$];
  dexp_t exp_done[$];

  logic [7:0]  ref_mem [int unsigned];
  logic [31:0] smem [int unsigned];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int issued = 0;
  int done_cnt = 0;
  int last_done_cyc = 0;
  int last_b_cyc = 0;
  int aw_hi = 0;
  int w_hi = 0;
  logic [31:0] exp_last_rd = 32'd0;

  int ar_lat = 0, aw_lat = 0, w_lat = 0, r_lat = 0, b_lat = 0;
  logic [1:0] r_resp = 2'b00;
  logic [1:0] b_resp = 2'b00;

  int ar_c, aw_c, w_c, r_c, b_c;
  bit r_pend, b_pend, aw_got, w_got;
  logic [31:0] r_word, aw_a, w_d, m_word;
  logic [3:0]  w_s;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_byte(a);
  endfunction

  function automatic logic [31:0] slave_word(input logic [31:0] a);
    logic [31:0] b;
    b = a & 32'hFFFF_FFFC;
    if (smem.exists(a >> 2)) return smem[a >> 2];
    return {init_byte(b + 3), init_byte(b + 2),
            init_byte(b + 1), init_byte(b)};
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    logic [31:0] b;
    b = a & 32'hFFFF_FFFC;
    smem[a >> 2] = v;
    for (int i = 0; i < 4; i++) ref_mem[b + i] = v[8*i +: 8];
  endtask

  task automatic push_exp(input bit w, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] d);
    int n;
    int lane;
    logic [31:0] base;
    logic [31:0] al;
    logic [3:0]  strb;
    logic [2:0]  lg;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    lg = (n == 4) ? 3'd2 : (n == 2) ? 3'd1 : 3'd0;
    base = a - (a % n);
    strb = 4'd0;
    if (w) begin
      for (int i = 0; i < n; i++) begin
        lane = int'(base % 4) + i;
        strb[lane] = 1'b1;
        ref_mem[base + i] = d[8*lane +: 8];
      end
      exp_aw.push_back('{a, lg});
      exp_w.push_back('{d, strb});
      exp_done.push_back('{1'b0, 32'd0});
    end else begin
      al = a & 32'hFFFF_FFFC;
      exp_ar.push_back('{a, lg});
      exp_done.push_back('{1'b1, {ref_byte(al + 3), ref_byte(al + 2),
                                  ref_byte(al + 1), ref_byte(al)}});
    end
    issued++;
  endtask

  task automatic issue(input bit w, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] d,
                       output int acc);
    bit ok;
    ok = 1'b0;
    acc = -1;
    @(posedge clk); #1;
    bus.req = 1'b1;
    bus.wr = w;
    bus.size = sz;
    bus.addr = a;
    bus.wdata = d;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (bus.addr_ok) begin
        ok = 1'b1;
        acc = cyc;
        push_exp(w, sz, a, d);
      end
    end
    @(posedge clk); #1;
    bus.req = 1'b0;
    if (!ok) fail("accept");
  endtask

  task automatic wait_done(input string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge clk); #2;
      if (done_cnt == issued) ok = 1'b1;
    end
    if (!ok) begin
      fail(name);
      issued = done_cnt;
      exp_ar.delete();
      exp_aw.delete();
      exp_w.delete();
      exp_done.delete();
    end
  endtask

  // AXI slave model: latency-controlled readies, memory, R and B responses
  initial begin
    forever begin
      @(negedge clk);
      bus.rid = 4'd1;
      bus.bid = 4'd1;
      bus.rlast = 1'b1;
      if (rst) begin
        bus.arready = 1'b0;
        bus.awready = 1'b0;
        bus.wready = 1'b0;
        bus.rvalid = 1'b0;
        bus.bvalid = 1'b0;
        bus.rdata_axi = 32'd0;
        bus.rresp = 2'b00;
        bus.bresp = 2'b00;
        ar_c = 0; aw_c = 0; w_c = 0; r_c = 0; b_c = 0;
        r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
      end else begin
        bus.arready = bus.arvalid && (ar_c >= ar_lat);
        ar_c = (bus.arvalid && !bus.arready) ? ar_c + 1 : 0;
        bus.awready = bus.awvalid && (aw_c >= aw_lat);
        aw_c = (bus.awvalid && !bus.awready) ? aw_c + 1 : 0;
        bus.wready = bus.wvalid && (w_c >= w_lat);
        w_c = (bus.wvalid && !bus.wready) ? w_c + 1 : 0;
        bus.rvalid = 1'b0;
        if (r_pend) begin
          if (r_c >= r_lat) begin
            bus.rvalid = 1'b1;
            bus.rdata_axi = r_word;
            bus.rresp = r_resp;
          end else r_c++;
        end
        bus.bvalid = 1'b0;
        if (b_pend) begin
          if (b_c >= b_lat) begin
            bus.bvalid = 1'b1;
            bus.bresp = b_resp;
          end else b_c++;
        end
        if (bus.rvalid && bus.rready) r_pend = 0;
        if (bus.bvalid && bus.bready) b_pend = 0;
        if (bus.arvalid && bus.arready) begin
          r_pend = 1;
          r_c = 0;
          r_word = slave_word(bus.araddr);
        end
        if (bus.awvalid && bus.awready) begin
          aw_got = 1;
          aw_a = bus.awaddr;
        end
        if (bus.wvalid && bus.wready) begin
          w_got = 1;
          w_d = bus.wdata_axi;
          w_s = bus.wstrb;
        end
        if (aw_got && w_got) begin
          m_word = slave_word(aw_a);
          for (int i = 0; i < 4; i++)
            if (w_s[i]) m_word[8*i +: 8] = w_d[8*i +: 8];
          smem[aw_a >> 2] = m_word;
          aw_got = 0;
          w_got = 0;
          b_pend = 1;
          b_c = 0;
        end
      end
    end
  end

  // monitor: pops scoreboard entries at each handshake and completion
  initial begin
    aexp_t ea;
    wexp_t ew;
    dexp_t ed;
    forever begin
      @(negedge clk); #1;
      if (!rst) begin
        if (bus.awvalid) aw_hi++;
        if (bus.wvalid) w_hi++;
        if (bus.arvalid && bus.arready) begin
          if (exp_ar.size() == 0) fail("ar_unexpected");
          else begin
            ea = exp_ar.pop_front();
            check("ar_bus",
              {bus.arid, bus.araddr, bus.arsize, bus.arlen, bus.arburst,
               bus.arlock, bus.arcache, bus.arprot},
              {4'd1, ea.a, ea.sz, 4'd0, 2'b01, 2'b00, 4'd0, 3'd0});
          end
        end
        if (bus.awvalid && bus.awready) begin
          if (exp_aw.size() == 0) fail("aw_unexpected");
          else begin
            ea = exp_aw.pop_front();
            check("aw_bus",
              {bus.awid, bus.awaddr, bus.awsize, bus.awlen, bus.awburst,
               bus.awlock, bus.awcache, bus.awprot},
              {4'd1, ea.a, ea.sz, 4'd0, 2'b01, 2'b00, 4'd0, 3'd0});
          end
        end
        if (bus.wvalid && bus.wready) begin
          if (exp_w.size() == 0) fail("w_unexpected");
          else begin
            ew = exp_w.pop_front();
            check("w_bus", {bus.wid, bus.wdata_axi, bus.wstrb, bus.wlast},
                  {4'd1, ew.d, ew.s, 1'b1});
          end
        end
        if (bus.bvalid && bus.bready) last_b_cyc = cyc;
        if (bus.data_ok) begin
          check("addr_ok_in_done", bus.addr_ok, 0);
          if (exp_done.size() == 0) fail("data_ok_unexpected");
          else begin
            ed = exp_done.pop_front();
            if (ed.rd) begin
              check("rdata", bus.rdata, ed.d);
              exp_last_rd = ed.d;
            end else begin
              check("rdata_kept", bus.rdata, exp_last_rd);
            end
          end
          done_cnt++;
          last_done_cyc = cyc;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int acc;
    int acc2;
    int d0;
    int nacc;
    int accs [2];
    bit seen;
    rst = 1'b1;
    bus.req = 1'b0;
    bus.wr = 1'b0;
    bus.size = 2'd0;
    bus.addr = 32'd0;
    bus.wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1 bus.req = 1'b1;
    @(negedge clk);
    check("rst_addr_ok", bus.addr_ok, 0);
    check("rst_valids",
          {bus.arvalid, bus.awvalid, bus.wvalid, bus.rready, bus.bready,
           bus.data_ok}, 0);
    check("rst_rdata", bus.rdata, 0);
    check("rst_err", err, 0);
    @(posedge clk); #1;
    bus.req = 1'b0;
    rst = 1'b0;

    preload(32'hBFAF_8000, 32'h1234_5678);
    issue(1'b0, 2'd2, 32'hBFAF_8000, 32'd0, acc);
    wait_done("rd_word");
    check("rd_latency", last_done_cyc - acc, 3);
    repeat (5) @(negedge clk);
    check("rd_hold", bus.rdata, 32'h1234_5678);

    issue(1'b1, 2'd0, 32'hBFAF_F003, 32'hAB00_0000, acc);
    wait_done("wr_byte");
    check("wr_latency", last_done_cyc - acc, 3);
    check("b_to_data_ok", last_done_cyc - last_b_cyc, 1);
    issue(1'b0, 2'd2, 32'hBFAF_F000, 32'd0, acc);
    wait_done("rd_back");

    aw_lat = 3;
    w_lat = 0;
    aw_hi = 0;
    w_hi = 0;
    d0 = done_cnt;
    issue(1'b1, 2'd2, 32'hBFAF_8010, 32'hCAFE_F00D, acc);
    wait_done("wr_aw_delay");
    repeat (5) @(negedge clk);
    check("aw_held_cycles", aw_hi, 4);
    check("w_single_cycle", w_hi, 1);
    check("one_data_ok", done_cnt - d0, 1);
    aw_lat = 0;

    @(posedge clk); #1;
    bus.req = 1'b1;
    bus.wr = 1'b0;
    bus.size = 2'd2;
    bus.addr = 32'hBFAF_8010;
    nacc = 0;
    for (int k = 0; k < 60 && nacc < 2; k++) begin
      @(negedge clk);
      if (bus.addr_ok) begin
        accs[nacc] = cyc;
        push_exp(1'b0, 2'd2, 32'hBFAF_8010, 32'd0);
        nacc++;
      end
    end
    @(posedge clk); #1;
    bus.req = 1'b0;
    wait_done("req_held");
    if (nacc < 2) fail("req_held_reaccept");
    else begin
      check("reaccept_gap", accs[1] - accs[0], 4);
      check("second_latency", last_done_cyc - accs[1], 3);
    end

    r_lat = 20;
    issue(1'b0, 2'd2, 32'hBFAF_8000, 32'd0, acc);
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      if (bus.rready) seen = 1'b1;
    end
    if (!seen) fail("reach_r_state");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_valids",
          {bus.arvalid, bus.awvalid, bus.wvalid, bus.rready, bus.bready,
           bus.data_ok}, 0);
    check("rst_mid_rdata", bus.rdata, 0);
    rst = 1'b0;
    exp_done.delete();
    exp_ar.delete();
    issued = done_cnt;
    exp_last_rd = 32'd0;
    r_lat = 0;
    d0 = done_cnt;
    repeat (10) @(negedge clk);
    check("no_data_ok_after_rst", done_cnt, d0);
    issue(1'b0, 2'd2, 32'hBFAF_8000, 32'd0, acc);
    wait_done("post_rst_read");
    check("post_rst_latency", last_done_cyc - acc, 3);

    b_resp = 2'b10;
    issue(1'b1, 2'd1, 32'hBFAF_8022, 32'h5555_AAAA, acc);
    wait_done("wr_slverr");
    b_resp = 2'b00;
    check("err_set", err, EXP_ERR);
    issue(1'b0, 2'd2, 32'hBFAF_8020, 32'd0, acc);
    wait_done("rd_after_err");
    check("err_sticky", err, EXP_ERR);

    for (int t = 0; t < 40; t++) begin
      ar_lat = $urandom_range(0, 3);
      aw_lat = $urandom_range(0, 3);
      w_lat = $urandom_range(0, 3);
      r_lat = $urandom_range(0, 3);
      b_lat = $urandom_range(0, 3);
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            32'h1FC0_0000 + 32'($urandom_range(0, 15)), $urandom, acc2);
      wait_done("random_txn");
    end
    check("err_final", err, EXP_ERR);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uncached_axi_master.md
# uncached_axi_master

Single-outstanding sram_like-to-AXI3 master for the CPU's uncached (confreg / MMIO) data path. It accepts one request at a time on the conf_data_* sram_like port from the data-side 1x2 bridge. It issues the matching single-beat AXI read or write and returns completion with a one-cycle data_ok pulse. It sits between that bridge and the AXI crossbar/interconnect.

## Interface
- Parameters:
- `AXI_ID`, default 4'd1: value driven on arid/awid/wid.
- Ports:
- `clk` input 1: clock.
- `rst` input 1: synchronous, active-high reset.
- `req` input 1: sram_like request valid.
- `wr` input 1: 1 = write, 0 = read.
- `size` input 2: 0 = byte, 1 = half, 2 = word; 3 is treated as word.
- `addr` input 32: byte address.
- `wdata` input 32: write data, lane-aligned.
- `rdata` output 32: read data, valid when data_ok.
- `addr_ok` output 1: request accepted this cycle.
- `data_ok` output 1: one-cycle completion pulse.
- `arid`/`araddr`/`arlen`/`arsize`/`arburst`/`arlock`/`arcache`/`arprot`/`arvalid` output 4/32/4/3/2/2/4/3/1; `arready` input 1.
- `rid`/`rdata_axi`/`rresp`/`rlast`/`rvalid` input 4/32/2/1/1; `rready` output 1.
- `awid`/`awaddr`/`awlen`/`awsize`/`awburst`/`awlock`/`awcache`/`awprot`/`awvalid` output (widths as AR); `awready` input 1.
- `wid`/`wdata_axi`/`wstrb`/`wlast`/`wvalid` output 4/32/4/1/1; `wready` input 1.
- `bid`/`bresp`/`bvalid` input 4/2/1; `bready` output 1.
- `err` output 1: sticky bus-error flag (see Configuration).

## Operation
- FSM states: IDLE, AR, R, AW_W, B, DONE.
- `addr_ok = req & (state==IDLE)`, combinational. On accept, latch addr, size (3→2), wdata and wr.
  - IDLE→AR when wr=0; IDLE→AW_W when wr=1.
- AR: arvalid=1, arlen=0, arsize={1'b0,size_q}, arburst=2'b01, lock/cache/prot=0. On arready → R.
- R: rready=1. On rvalid, latch rdata_axi into the rdata register → DONE. rid and rlast are ignored.
- AW_W: awvalid and wvalid are raised together. Each drops independently after its own handshake (aw_done/w_done flags). The state advances to B once both have handshaked; same-cycle or either order is legal.
  - wlast=1.
  - wstrb: byte = 4'b0001<<addr[1:0]; half = addr[1] ? 4'b1100 : 4'b0011; word = 4'b1111.
  - wdata_axi = latched wdata, unmodified.
- B: bready=1. On bvalid → DONE. bid is ignored.
- DONE: data_ok=1 for exactly one cycle → IDLE. addr_ok is 0 in DONE, so a req still held high by upstream is not re-accepted until the next IDLE cycle.
- rdata holds the last read value until the next read completes. Writes do not alter it.
- No alignment check: addr passes to araddr/awaddr unchanged.

## Timing
- Reset values: state IDLE; all AXI valid/ready outputs 0; addr_ok=0 (since req is gated in reset); data_ok 0; rdata 0; err 0; aw_done/w_done 0.
- Read, zero-wait slave: accept t0, arvalid t1 with arready t1, rready t2 with rvalid t2, data_ok t3. Minimum latency is 3 cycles from accept.
- Write, zero-wait slave: accept t0, aw/w valid t1, bvalid t2, data_ok t3.
- All AXI outputs are registered or decoded from state. No combinational path exists from any AXI input to any AXI output.
- Reset mid-transaction abandons it immediately: all valids drop the cycle after rst is sampled. The system reset also resets the interconnect.

## Configuration
- `UNCACHED_RESP_CHECK_EN` defined:
  - rresp or bresp ≠ 2'b00 at handshake sets `err`, which stays set until rst.
  - The transaction still completes normally with data_ok.
- Not defined: `err` is tied to 0 and resp inputs are unused.

## Test plan
- Word read 0xBFAF_8000, zero-wait slave returns 0x1234_5678 → arsize=2, arlen=0, data_ok at t0+3, rdata=0x1234_5678, held afterwards.
- Byte write addr 0xBFAF_F003, wdata 0xAB00_0000 → awsize=0, wstrb=4'b1000, wlast=1, data_ok one cycle after bvalid.
- Write with awready delayed 3 cycles and wready immediate → wvalid drops after its own handshake, awvalid is held until accepted, and exactly one data_ok.
- req held high through data_ok → no second addr_ok in DONE. A new request is accepted only in the following IDLE cycle.
- Assert rst while in R with rvalid pending → next cycle all valids/readies are 0, state is IDLE, no data_ok.
- With `UNCACHED_RESP_CHECK_EN`, bresp=2'b10 → err=1 and stays 1 across later OKAY transactions. Without the macro, err=0.
